flappy_painter_gen: RTL



---
 rtl/flappy_painter_gen.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/flappy_painter_gen.sv
// Serialises one flappy frame (player box + NUM_PIPES pipes) onto the VGA pixel port,
// erasing the previous frame from latched coordinates. Optional macro: PIPE_CAP_EN.
module flappy_painter_gen #(
  parameter int NUM_PIPES = 3,
  parameter int PIPE_W    = 2,
  parameter int GAP_LEN   = 30,
  parameter int BOX_SIZE  = 3,
  parameter int BOX_X     = 4,
  parameter int SCREEN_W  = 320,
  parameter int SCREEN_H  = 120
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic                   game_pulse,
  input  logic                   key_press,
  input  logic                   collided,
  input  logic [6:0]             box_y,
  input  logic [9*NUM_PIPES-1:0] pipe_x_flat,
  input  logic [7*NUM_PIPES-1:0] pipe_y_flat,
  output logic                   plot,
  output logic [8:0]             x,
  output logic [6:0]             y,
  output logic [2:0]             colour,
  output logic                   frame_done,
  output logic                   busy
);

  typedef enum logic [2:0] {S_IDLE, S_LATCH, S_DRAW, S_WAIT, S_ERASE, S_DONE} state_t;

  localparam int              PW        = $clog2(NUM_PIPES + 1);
  localparam logic [PW-1:0]   LAST_PASS = PW'(NUM_PIPES);
  localparam logic [6:0]      BOX_LAST  = 7'(BOX_SIZE - 1);
  localparam logic [6:0]      ROW_LAST  = 7'(SCREEN_H - 1);
  localparam logic [6:0]      COL_LAST  = 7'(PIPE_W - 1);
  localparam logic [2:0]      RED       = 3'b100;
  localparam logic [2:0]      GREEN     = 3'b010;
  localparam logic [2:0]      BLACK     = 3'b000;

  state_t        state, state_n;
  logic [PW-1:0] pass;            // 0 = box pass, i+1 = pipe i
  logic [6:0]    inner, outer;
  logic          seq_active, inner_last, outer_last, phase_end;

  logic [6:0]    sh_box_y;
  logic [8:0]    sh_px [NUM_PIPES];
  logic [6:0]    sh_gy [NUM_PIPES];

  logic [8:0]    cur_px;
  logic [6:0]    cur_gy;
  logic [9:0]    x_sum;
  logic [6:0]    y_pix;
  logic [7:0]    y8, gap_lo, gap_hi;
  logic          in_gap, pix_on;
  logic [2:0]    pix_colour;

  assign seq_active = (state == S_DRAW) || (state == S_ERASE);
  assign inner_last = (inner == ((pass == '0) ? BOX_LAST : ROW_LAST));
  assign outer_last = (outer == ((pass == '0) ? BOX_LAST : COL_LAST));
  assign phase_end  = inner_last && outer_last && (pass == LAST_PASS);

  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (key_press)  state_n = S_LATCH;
      S_LATCH:                 state_n = S_DRAW;
      S_DRAW:  if (phase_end)  state_n = S_WAIT;
      S_WAIT:  if (game_pulse) state_n = S_ERASE;
      S_ERASE: if (phase_end)  state_n = S_DONE;
      S_DONE:                  state_n = collided ? S_IDLE : S_LATCH;
      default:                 state_n = S_IDLE;
    endcase
  end

  // Counters idle at zero outside DRAW/ERASE, so each phase starts from the box pass.
  always_ff @(posedge CLOCK_50) begin
    if (reset || !seq_active) begin
      pass  <= '0;
      inner <= '0;
      outer <= '0;
    end else if (inner_last) begin
      inner <= '0;
      if (outer_last) begin
        outer <= '0;
        pass  <= pass + 1'b1;
      end else begin
        outer <= outer + 1'b1;
      end
    end else begin
      inner <= inner + 1'b1;
    end
  end

  // NOTE: the shadow set is only a handful of flops, so it is reset like ordinary
  // state; an erase straight after reset then paints a known frame, never X.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sh_box_y <= '0;
      for (int i = 0; i < NUM_PIPES; i++) begin
        sh_px[i] <= '0;
        sh_gy[i] <= '0;
      end
    end else if (state == S_LATCH) begin
      sh_box_y <= box_y;
      for (int i = 0; i < NUM_PIPES; i++) begin
        sh_px[i] <= pipe_x_flat[9*i +: 9];
        sh_gy[i] <= pipe_y_flat[7*i +: 7];
      end
    end
  end

  always_comb begin
    cur_px = '0;
    cur_gy = '0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      if (pass == PW'(i + 1)) begin
        cur_px = sh_px[i];
        cur_gy = sh_gy[i];
      end
    end
  end

  // Gap bounds are 8 bits wide so gy+GAP_LEN never wraps back into low rows.
  assign y8     = {1'b0, inner};
  assign gap_lo = {1'b0, cur_gy};
  assign gap_hi = gap_lo + 8'(GAP_LEN);

  always_comb begin
    x_sum      = '0;
    y_pix      = '0;
    in_gap     = 1'b0;
    pix_colour = BLACK;
    if (pass == '0) begin
      x_sum = 10'(BOX_X) + {3'b000, inner};
      y_pix = sh_box_y + outer;
      if (state == S_DRAW) pix_colour = RED;
    end else begin
      x_sum  = {1'b0, cur_px} + {3'b000, outer};
      y_pix  = inner;
      in_gap = (y8 >= gap_lo) && (y8 < gap_hi);
      if (state == S_DRAW) begin
`ifdef PIPE_CAP_EN
        if (((cur_gy != '0) && (y8 == gap_lo - 8'd1)) ||
            ((y8 == gap_hi) && (gap_hi < 8'(SCREEN_H))))
          pix_colour = 3'b110;
        else
          pix_colour = GREEN;
`else
        pix_colour = GREEN;
`endif
      end
    end
  end

  assign pix_on = !in_gap && !x_sum[9] && (x_sum < 10'(SCREEN_W));

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      plot       <= 1'b0;
      x          <= '0;
      y          <= '0;
      colour     <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      plot       <= seq_active && pix_on;
      x          <= x_sum[8:0];
      y          <= y_pix;
      colour     <= pix_colour;
      frame_done <= (state == S_DONE);
      busy       <= (state == S_LATCH) || seq_active || (state == S_DONE);
    end
  end

endmodule
